// File: rtl/demux_n_reg.sv
// One-to-N demultiplexer with a one-entry register per output channel, fixed or round-robin steering.
// Optional DEMUX_ZERO_IDLE_EN: drive idle channels' out_data to zero instead of holding the last beat.
module demux_n_reg #(
  parameter int DATA_WIDTH = 256,
  parameter int NUM_OUTS   = 4,
  localparam int SEL_WIDTH = (NUM_OUTS > 2) ? $clog2(NUM_OUTS) : 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [DATA_WIDTH-1:0]          in_data,
  input  logic [SEL_WIDTH-1:0]           in_sel,
  input  logic                           rr_mode,
  output logic [NUM_OUTS-1:0]            out_valid,
  input  logic [NUM_OUTS-1:0]            out_ready,
  output logic [NUM_OUTS*DATA_WIDTH-1:0] out_data,
  output logic                           err_sticky,
  input  logic                           err_clr
);

  logic [SEL_WIDTH-1:0]  rr_ptr;
  logic [SEL_WIDTH-1:0]  target;
  logic [NUM_OUTS-1:0]   full;
  logic [NUM_OUTS-1:0]   hit;
  logic [NUM_OUTS-1:0]   load;
  logic [DATA_WIDTH-1:0] data [NUM_OUTS];
  logic                  bad_sel;
  logic                  accept;

  assign target  = rr_mode ? rr_ptr : in_sel;
  assign bad_sel = !rr_mode && (32'(in_sel) >= 32'(NUM_OUTS));

  genvar gi;
  generate
    for (gi = 0; gi < NUM_OUTS; gi++) begin : g_chan
      assign hit[gi] = (target == SEL_WIDTH'(gi));
`ifdef DEMUX_ZERO_IDLE_EN
      assign out_data[gi*DATA_WIDTH +: DATA_WIDTH] = data[gi] & {DATA_WIDTH{full[gi]}};
`else
      assign out_data[gi*DATA_WIDTH +: DATA_WIDTH] = data[gi];
`endif
    end
  endgenerate

  // A bad select has no matching channel, so it is always accepted and simply dropped.
  assign in_ready  = bad_sel | (|(hit & (~full | out_ready)));
  assign accept    = in_valid & in_ready;
  assign load      = hit & {NUM_OUTS{accept & ~bad_sel}};
  assign out_valid = full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full <= '0;
      for (int k = 0; k < NUM_OUTS; k++) data[k] <= '0;
    end else begin
      // Loading wins over draining, which gives bubble-free pass-through.
      full <= load | (full & ~out_ready);
      for (int k = 0; k < NUM_OUTS; k++)
        if (load[k]) data[k] <= in_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (accept && rr_mode) begin
      rr_ptr <= (rr_ptr == SEL_WIDTH'(NUM_OUTS - 1)) ? '0 : rr_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_sticky <= 1'b0;
    end else if (accept && bad_sel) begin
      err_sticky <= 1'b1;
    end else if (err_clr) begin
      err_sticky <= 1'b0;
    end
  end

endmodule

// File: doc/demux_n_reg.md
DEMUX_N_REG -- requirements
Module: demux_n_reg

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 256, meaning the width of one data beat.
REQ-002 SHALL have parameter NUM_OUTS, default 4, meaning the number of output channels (legal range 2..16).
REQ-003 SHALL have localparam SEL_WIDTH = max(1, clog2(NUM_OUTS)), meaning the select width.
REQ-004 SHALL have port clk  input  1  system clock; all logic is on the rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-006 SHALL have port in_valid  input  1  input beat valid.
REQ-007 SHALL have port in_ready  output  1  input beat accepted when high together with in_valid.
REQ-008 SHALL have port in_data  input  DATA_WIDTH  input beat.
REQ-009 SHALL have port in_sel  input  SEL_WIDTH  destination channel, used in fixed mode.
REQ-010 SHALL have port rr_mode  input  1  0 = fixed select, 1 = round-robin distribution.
REQ-011 SHALL have port out_valid  output  NUM_OUTS  per-channel valid.
REQ-012 SHALL have port out_ready  input  NUM_OUTS  per-channel ready.
REQ-013 SHALL have port out_data  output  NUM_OUTS*DATA_WIDTH  channel k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-014 SHALL have port err_sticky  output  1  out-of-range select seen.
REQ-015 SHALL have port err_clr  input  1  clears err_sticky.

Function
REQ-016 SHALL give each channel a one-entry output register with a full flag; out_valid[k] equals the full flag of channel k.
REQ-017 SHALL accept an input beat (in_valid & in_ready) and make it visible at the target channel exactly 1 cycle later.
REQ-018 SHALL take the target from in_sel when rr_mode=0 and from the internal pointer rr_ptr when rr_mode=1.
REQ-019 SHALL drive in_ready high when the target channel is empty, or when it is full and out_ready for that channel is high in the same cycle (pass-through without a bubble).
REQ-020 SHALL keep in_ready combinationally free of in_valid.
REQ-021 SHALL clear a channel's full flag on out_valid & out_ready, unless a new beat is loaded into that channel in the same cycle, in which case the flag stays set and the data is replaced.
REQ-022 SHALL hold out_data[k] stable while out_valid[k]=1 and out_ready[k]=0.
REQ-023 SHALL advance rr_ptr by 1 only on an accepted beat with rr_mode=1, wrap from NUM_OUTS-1 to 0, and otherwise hold it.
REQ-024 SHALL, in fixed mode with in_sel >= NUM_OUTS, drive in_ready=1, discard the beat, leave every channel unchanged, and set err_sticky on the next edge.
REQ-025 SHALL clear err_sticky on err_clr=1; a new error in the same cycle as err_clr SHALL take priority and leave err_sticky at 1.
REQ-026 SHALL never load more than one channel per cycle, and SHALL drain each channel independently of the others.

Reset
REQ-027 SHALL, on rst asserted, asynchronously clear all full flags, rr_ptr and err_sticky to 0; out_valid SHALL be 0 and in_ready SHALL follow REQ-019 (high, since all channels are empty).
REQ-028 SHALL drop any held beat when rst is asserted mid-transfer; no beat from before reset SHALL appear after it.
REQ-029 SHALL reset out_data registers to 0.

Configuration
REQ-030 SHALL support macro DEMUX_ZERO_IDLE_EN: when defined, out_data[k] SHALL read all-zero whenever out_valid[k]=0; when undefined, out_data[k] SHALL hold the last loaded beat after it drains.

Verification
REQ-031 Fixed mode, in_sel=2, in_data=0xA5, all out_ready=1 -> out_valid=4'b0100 and channel 2 data=0xA5 one cycle later; valid low the following cycle.
REQ-032 Channel 1 full with out_ready[1]=0, beat for channel 1 offered -> in_ready=0 and the beat is held; raise out_ready[1] -> in_ready=1 the same cycle and the new beat appears next cycle with no bubble.
REQ-033 rr_mode=1, 5 back-to-back beats 0..4 with NUM_OUTS=4 -> beats land on channels 0,1,2,3,0 and rr_ptr ends at 1.
REQ-034 NUM_OUTS=3, in_sel=3 -> in_ready=1, no out_valid rises, err_sticky=1; err_clr pulsed together with a second bad select -> err_sticky stays 1.
REQ-035 rst pulsed while channels 0 and 3 are full -> out_valid=0 and err_sticky=0 immediately, without waiting for a clock edge; the next accepted round-robin beat goes to channel 0.
REQ-036 With and without DEMUX_ZERO_IDLE_EN, load then drain 0xFF on channel 0 -> idle out_data is 0 when defined and 0xFF when undefined.
